// File: rtl/d_flip_flop.sv
// d_flip_flop: rising-edge D register with a synchronous active-high clear
// and complementary outputs. Width and clear value are parameters so the
// same cell serves as a single registered bit or as a full word register.
module d_flip_flop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] r_q;

  // Load d on every rising edge; clear wins over data on the same edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_q <= CLEAR_VALUE;
    end else begin
      r_q <= d;
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: drives a default 1-bit instance and an 8-bit instance
// cleared to A5 with directed and randomized stimulus, comparing both
// against a reference model of the register's update rule.
module tb_d_flip_flop;

  localparam logic [7:0] WIDE_CLEAR = 8'hA5;

  logic       clk = 1'b0;
  logic       clear1;
  logic       d1;
  logic       q1;
  logic       qbar1;
  logic       clear8;
  logic [7:0] d8;
  logic [7:0] q8;
  logic [7:0] qbar8;

  int total = 0;
  int bad   = 0;

  logic       exp1;
  logic [7:0] exp8;

  // Free-running clock, period 20, rising edges at 10, 30, 50, ...
  always #10 clk = ~clk;

  d_flip_flop dutNarrow (
    .clk  (clk),
    .clear(clear1),
    .d    (d1),
    .q    (q1),
    .qbar (qbar1)
  );

  d_flip_flop #(
    .WIDTH      (8),
    .CLEAR_VALUE(WIDE_CLEAR)
  ) dutWide (
    .clk  (clk),
    .clear(clear8),
    .d    (d8),
    .q    (q8),
    .qbar (qbar8)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Compare both instances against the model's current register contents.
  task automatic checkBoth(input string phase);
    logic       nexp1;
    logic [7:0] wq1;
    logic [7:0] wqb1;
    logic [7:0] wexp1;
    logic [7:0] wnexp1;
    nexp1  = ~exp1;
    wq1    = {7'b0, q1};
    wqb1   = {7'b0, qbar1};
    wexp1  = {7'b0, exp1};
    wnexp1 = {7'b0, nexp1};
    checkOutput({phase, " q1"},    wq1,   wexp1);
    checkOutput({phase, " qbar1"}, wqb1,  wnexp1);
    checkOutput({phase, " q8"},    q8,    exp8);
    checkOutput({phase, " qbar8"}, qbar8, ~exp8);
  endtask

  // Apply one cycle of inputs on the falling edge, optionally glitching them
  // mid-cycle, then advance the model on the rising edge and check.
  task automatic applyStimulus(input logic c1, input logic v1,
                               input logic c8, input logic [7:0] v8,
                               input bit glitch);
    @(negedge clk);
    clear1 = c1;
    d1     = v1;
    clear8 = c8;
    d8     = v8;
    #2;
    if (glitch) begin
      clear1 = ~c1;
      d1     = ~v1;
      clear8 = ~c8;
      d8     = ~v8;
    end
    #2;
    checkBoth("midcycle");
    #2;
    clear1 = c1;
    d1     = v1;
    clear8 = c8;
    d8     = v8;
    @(posedge clk);
    exp1 = c1 ? 1'b0 : v1;
    exp8 = c8 ? WIDE_CLEAR : v8;
    #1;
    checkBoth("edge");
  endtask

  initial begin
    clear1 = 1'b1;
    d1     = 1'b0;
    clear8 = 1'b1;
    d8     = 8'h00;

    // First edge at 10 with clear held: both registers take their clear value.
    @(posedge clk);
    exp1 = 1'b0;
    exp8 = WIDE_CLEAR;
    #1;
    checkBoth("first-clear");

    // Hold clear through t=100.
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);

    // Release at t=100 with d=1 / 3C; loads at the edge at 110.
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0);

    // d=0 from t=200, d=1 from t=300.
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 8'hC3, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 8'h5A, 1'b0);

    // Clear raised mid-cycle with d=1: q holds until the edge, then clears.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);

    // Reload, then glitch inputs between edges without disturbing q.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Randomized traffic with occasional clears and mid-cycle glitches.
    for (int i = 0; i < 200; i++) begin
      logic       rc1;
      logic       rc8;
      logic       rv1;
      logic [7:0] rv8;
      bit         rg;
      rc1 = ($urandom_range(0, 7) == 0);
      rc8 = ($urandom_range(0, 7) == 0);
      rv1 = 1'($urandom);
      rv8 = 8'($urandom);
      rg  = 1'($urandom);
      applyStimulus(rc1, rv1, rc8, rv8, rg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
